// File: rtl/aes_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared types and defaults for the aes_128 request scheduler.
//   aes_blk_t     : one 128-bit AES block (plaintext, key or ciphertext)
//   aes_id_t      : originating requester port (0 or 1)
//   pipe_entry_t  : one stage of the in-flight tracking pipe {valid, id}
//   rsp_entry_t   : one output FIFO word {id, data}, 129 bits
// -----------------------------------------------------------------------------
package aes_ctrl_pkg;

    localparam int AES_CORE_LAT_DEFAULT   = 21;
    localparam int AES_FIFO_DEPTH_DEFAULT = 32;

    typedef logic [127:0] aes_blk_t;
    typedef logic         aes_id_t;

    typedef struct packed {
        logic    valid;
        aes_id_t id;
    } pipe_entry_t;

    typedef struct packed {
        aes_id_t  id;
        aes_blk_t data;
    } rsp_entry_t;

endpackage

// File: rtl/aes_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// aes_ctrl_fifo
// Synchronous FIFO holding completed AES results ({id, ciphertext}).
// The head entry is held in output registers, so a word written into an
// empty FIFO becomes visible on rd_valid/rd_data the cycle after the write,
// and rd_data reads as 0 whenever the FIFO is empty.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   wr_en      : write wr_data this cycle (must not overflow)
//   wr_data    : entry to store
//   rd_en      : consumer accepts the head entry (ignored when empty)
//   rd_valid   : head entry present
//   rd_data    : head entry
//   count      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module aes_ctrl_fifo
    import aes_ctrl_pkg::*;
#(
    parameter int DEPTH = AES_FIFO_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  rsp_entry_t       wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output rsp_entry_t       rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    rsp_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_after_pop;
    rsp_entry_t       head_q, head_d;
    logic             head_valid_q, head_valid_d;
    logic             do_pop;

    // The head register is loaded with whatever will sit at rd_ptr after this
    // cycle's pop/write. If the FIFO drains to empty in the same cycle as a
    // write, the new word bypasses memory straight into the head register.
    always_comb begin
        do_pop          = rd_en & head_valid_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_after_pop = count_q - CNT_W'(do_pop);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d      = count_after_pop + CNT_W'(wr_en);
        head_valid_d = (count_d != '0);
        if (count_after_pop == '0) begin
            head_d = wr_en ? wr_data : '0;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    // Storage needs no reset: only entries between rd_ptr and wr_ptr are read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Upstream credit accounting must make a write into a full FIFO impossible.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !do_pop && count_q == FULL));

    assign rd_valid = head_valid_q;
    assign rd_data  = head_q;
    assign count    = count_q;

endmodule

// File: rtl/aes_128_ctrl.sv
// -----------------------------------------------------------------------------
// aes_128_ctrl
// Request scheduler for a fully pipelined aes_128 core that has no valid or
// stall of its own. Two requesters are arbitrated round-robin; a {valid, id}
// shift pipe of CORE_LAT stages follows each block through the core, and the
// finished ciphertext is captured into an output FIFO. A block is issued only
// when a FIFO slot is reserved for it (credit), so results are never dropped
// under response backpressure.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   reqN_valid/ready/state/key : requester N (N = 0, 1), valid/ready handshake
//   core_state, core_key       : block presented to the core (0 when idle)
//   core_out                   : core result, CORE_LAT cycles after the sample
//   rsp_valid/ready/data/id    : response stream, in issue order
//   busy                       : a block is in flight or buffered
//   cnt0, cnt1                 : responses delivered per port
// Optional feature: define AES_CTRL_STATS_EN to build the cnt0/cnt1 counters;
// otherwise both ports read 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module aes_128_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int CORE_LAT   = AES_CORE_LAT_DEFAULT,
    parameter int FIFO_DEPTH = AES_FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_state,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_state,
    input  logic [127:0] req1_key,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         busy,
    output logic [31:0]  cnt0,
    output logic [31:0]  cnt1
);

    localparam int             CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    aes_id_t          last_q, last_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    pipe_entry_t      pipe_q [CORE_LAT];
    pipe_entry_t      pipe_d [CORE_LAT];

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             credit_ok;
    logic             grant0, grant1;
    logic             issue;
    aes_id_t          issue_id;
    logic             capture;
    rsp_entry_t       fifo_wr_data;
    rsp_entry_t       fifo_rd_data;

    // Credit is FIFO_DEPTH minus everything already owed a FIFO slot (buffered
    // plus in flight). fifo_count is registered, so a pop only frees credit
    // from the following cycle on.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
        credit_ok = (occupancy < DEPTH_LIM);
    end

    // Round-robin: with both ports valid the port that did not win last time
    // is granted; last_q resets to 1 so port 0 wins the first contest.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_q);
        grant1     = req1_valid & (~req0_valid | ~last_q);
        req0_ready = rst_n & grant0 & credit_ok;
        req1_ready = rst_n & grant1 & credit_ok;
        issue      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        issue_id   = req1_valid & req1_ready;
        last_d     = issue ? issue_id : last_q;
        core_state = '0;
        core_key   = '0;
        if (req0_valid & req0_ready) begin
            core_state = req0_state;
            core_key   = req0_key;
        end else if (req1_valid & req1_ready) begin
            core_state = req1_state;
            core_key   = req1_key;
        end
    end

    // The pipe mirrors the core's latency; its tail marks the cycle in which
    // core_out holds a real result. Stale core contents after a reset are
    // ignored because their pipe bits were cleared.
    always_comb begin
        pipe_d[0].valid = issue;
        pipe_d[0].id    = issue_id;
        for (int i = 1; i < CORE_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        capture           = pipe_q[CORE_LAT-1].valid;
        fifo_wr_data.id   = pipe_q[CORE_LAT-1].id;
        fifo_wr_data.data = core_out;
        inflight_d        = inflight_q + CNT_W'(issue) - CNT_W'(capture);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            inflight_q <= '0;
            for (int i = 0; i < CORE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            last_q     <= last_d;
            inflight_q <= inflight_d;
            pipe_q     <= pipe_d;
        end
    end

    aes_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (capture),
        .wr_data  (fifo_wr_data),
        .rd_en    (rsp_ready),
        .rd_valid (rsp_valid),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

    assign rsp_data = fifo_rd_data.data;
    assign rsp_id   = fifo_rd_data.id;
    assign busy     = rst_n & ((inflight_q != '0) | (fifo_count != '0));

`ifdef AES_CTRL_STATS_EN
    logic [31:0] cnt0_q, cnt0_d;
    logic [31:0] cnt1_q, cnt1_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (rsp_valid & rsp_ready) begin
            if (rsp_id) begin
                cnt1_d = cnt1_q + 32'd1;
            end else begin
                cnt0_d = cnt0_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_aes_128_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_128_ctrl
// Self-checking bench for aes_128_ctrl. The AES core is stood in for by a
// CORE_LAT-deep delay line whose function returns the published ciphertext
// for the two FIPS-197 vectors and a simple keyed mix for anything else.
// Accepted requests push their expected response into a queue; a monitor
// pops and compares whenever a response handshake occurs, and also checks
// readiness against an accepted-minus-delivered credit model every cycle.
// -----------------------------------------------------------------------------
module tb_aes_128_ctrl;
    import aes_ctrl_pkg::*;

    localparam int CORE_LAT   = 21;
    localparam int FIFO_DEPTH = 32;

    localparam aes_blk_t FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_blk_t FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam aes_blk_t FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_blk_t APPX_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_blk_t APPX_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam aes_blk_t APPX_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct packed {
        logic     id;
        aes_blk_t data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    aes_blk_t     req0_state = '0;
    aes_blk_t     req0_key = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    aes_blk_t     req1_state = '0;
    aes_blk_t     req1_key = '0;
    aes_blk_t     core_state;
    aes_blk_t     core_key;
    aes_blk_t     core_out;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    aes_blk_t     rsp_data;
    logic         rsp_id;
    logic         busy;
    logic [31:0]  cnt0;
    logic [31:0]  cnt1;

    int       n_checks = 0;
    int       n_pass = 0;
    int       cyc = 0;
    aes_blk_t core_pipe [CORE_LAT];
    exp_t     exp_q [$];
    int       grant_log [$];
    int       acc_total = 0;
    int       pop_total = 0;
    int       rsp0_seen = 0;
    int       rsp1_seen = 0;
    logic     m_last = 1'b1;
    logic     prev_stall = 1'b0;
    logic     prev_id = 1'b0;
    aes_blk_t prev_data = '0;

    logic     mon_hs0, mon_hs1, mon_exp_ready, mon_exp_port;
    aes_blk_t mon_cs, mon_ck;
    exp_t     mon_e;
    int       mon_occ;

    aes_128_ctrl #(
        .CORE_LAT   (CORE_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_state (req0_state),
        .req0_key   (req0_key),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_state (req1_state),
        .req1_key   (req1_key),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic aes_blk_t aes_ref(input aes_blk_t st, input aes_blk_t ky);
        if (st == FIPS_PT && ky == FIPS_KEY) return FIPS_CT;
        if (st == APPX_PT && ky == APPX_KEY) return APPX_CT;
        return st ^ {ky[63:0], ky[127:64]};
    endfunction

    function automatic aes_blk_t mk_blk(input int tag, input int i);
        return {32'(tag), 64'h0123_4567_89ab_cdef, 32'(i)};
    endfunction

    // Stand-in for the pipelined core: never reset, CORE_LAT register stages.
    always @(posedge clk) begin
        core_pipe[0] <= aes_ref(core_state, core_key);
        for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[CORE_LAT-1];

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: credit/arbitration model, scoreboard push on accept, pop on response.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_total  = 0;
            pop_total  = 0;
            rsp0_seen  = 0;
            rsp1_seen  = 0;
            m_last     = 1'b1;
            prev_stall = 1'b0;
        end else begin
            mon_occ       = acc_total - pop_total;
            mon_exp_ready = (req0_valid | req1_valid) && (mon_occ < FIFO_DEPTH);
            check_output("ready_vs_credit", 256'(req0_ready | req1_ready), 256'(mon_exp_ready));
            check_output("busy", 256'(busy), 256'(mon_occ != 0));
            mon_hs0 = req0_valid & req0_ready;
            mon_hs1 = req1_valid & req1_ready;
            if (mon_hs0 | mon_hs1) begin
                mon_exp_port = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                check_output("grant_port", 256'(mon_hs1), 256'(mon_exp_port));
                check_output("one_grant", 256'(mon_hs0 & mon_hs1), 256'(0));
                mon_cs = mon_hs1 ? req1_state : req0_state;
                mon_ck = mon_hs1 ? req1_key : req0_key;
                check_output("core_bus", {core_state, core_key}, {mon_cs, mon_ck});
                exp_q.push_back('{id: mon_hs1, data: aes_ref(mon_cs, mon_ck)});
                grant_log.push_back(int'(mon_hs1));
                acc_total++;
                m_last = mon_hs1;
            end else begin
                check_output("core_bus_idle", {core_state, core_key}, 256'(0));
            end
            if (prev_stall) begin
                check_output("rsp_hold", 256'({rsp_valid, rsp_id, rsp_data}),
                             256'({1'b1, prev_id, prev_data}));
            end
            if (rsp_valid && rsp_ready) begin
                check_output("rsp_expected", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_output("rsp_data", 256'(rsp_data), 256'(mon_e.data));
                    check_output("rsp_id", 256'(rsp_id), 256'(mon_e.id));
                end
                pop_total++;
                if (rsp_id) rsp1_seen++;
                else rsp0_seen++;
            end
            prev_stall = rsp_valid & ~rsp_ready;
            prev_id    = rsp_id;
            prev_data  = rsp_data;
        end
    end

    task automatic apply_stimulus(input logic port, input aes_blk_t st, input aes_blk_t ky,
                                  output int acc_cyc);
        if (port) begin
            req1_valid = 1'b1; req1_state = st; req1_key = ky;
        end else begin
            req0_valid = 1'b1; req0_state = st; req0_key = ky;
        end
        acc_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (acc_cyc < 0) check_output("accept_timeout", 256'(acc_cyc), 256'(cyc));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        int ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check_output("drain", 256'(ok), 256'(1));
    endtask

    task automatic stream_cycles(input int n, input int first, input bit bp_pattern);
        for (int i = 0; i < n; i++) begin
            req0_state = mk_blk(32'hA0, first + i);
            req0_key   = mk_blk(32'hA1, first + i);
            req1_state = mk_blk(32'hB0, first + i);
            req1_key   = mk_blk(32'hB1, first + i);
            if (bp_pattern) rsp_ready = (i >= 40) && (i % 4 != 3);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_acc;
        int seen;
        int cnt_a;
        int cnt_b;
        int exp0;
        int exp1;

        // Reset state, with a request pending to show ready is held low.
        req0_valid = 1'b1;
        req0_state = FIPS_PT;
        req0_key   = FIPS_KEY;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_req0_ready", 256'(req0_ready), 256'(0));
        check_output("rst_core_state", 256'(core_state), 256'(0));
        check_output("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        check_output("rst_rsp_data", 256'(rsp_data), 256'(0));
        check_output("rst_rsp_id", 256'(rsp_id), 256'(0));
        check_output("rst_busy", 256'(busy), 256'(0));
        check_output("rst_cnt", {cnt0, cnt1}, 256'(0));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst_n = 1'b1;

        // FIPS-197 single block and its latency.
        $display("[TB] FIPS-197 single block");
        rsp_ready = 1'b1;
        apply_stimulus(1'b0, FIPS_PT, FIPS_KEY, t_acc);
        seen = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = cyc;
                break;
            end
        end
        check_output("fips_latency", 256'(seen - t_acc), 256'(CORE_LAT + 1));
        check_output("fips_data", 256'(rsp_data), 256'(FIPS_CT));
        check_output("fips_id", 256'(rsp_id), 256'(0));
        wait_drain();

        // Round-robin with both ports continuously valid.
        $display("[TB] round-robin");
        do_reset();
        grant_log.delete();
        req0_state = FIPS_PT; req0_key = FIPS_KEY;
        req1_state = APPX_PT; req1_key = APPX_KEY;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 40 && grant_log.size() < 8; i++) begin
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_output("rr_count", 256'(grant_log.size() >= 8), 256'(1));
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check_output($sformatf("rr_grant%0d", i), 256'(grant_log[i]), 256'(i % 2));
        end
        wait_drain();

        // Backpressure: exactly FIFO_DEPTH accepts, then in-order drain and resume.
        $display("[TB] backpressure");
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        stream_cycles(70, 0, 1'b0);
        check_output("bp_accepts", 256'(acc_total), 256'(FIFO_DEPTH));
        @(negedge clk);
        check_output("bp_ready_low", 256'(req0_ready | req1_ready), 256'(0));
        check_output("bp_rsp_valid", 256'(rsp_valid), 256'(1));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        stream_cycles(40, 100, 1'b0);
        check_output("bp_resume", 256'(acc_total > FIFO_DEPTH), 256'(1));
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();
        check_output("bp_all_delivered", 256'(pop_total), 256'(acc_total));

        // Credit at its limit with issue, capture and pop in the same cycle.
        $display("[TB] credit limit");
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        stream_cycles(200, 300, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        check_output("cr_all_delivered", 256'(pop_total), 256'(acc_total));

        // Reset while five blocks are in flight.
        $display("[TB] reset mid-flight");
        do_reset();
        rsp_ready = 1'b1;
        apply_stimulus(1'b0, FIPS_PT, FIPS_KEY, t_acc);
        for (int k = 1; k < 5; k++) apply_stimulus(k[0], mk_blk(32'hC0, k), mk_blk(32'hC1, k), seen);
        while (cyc < t_acc + 10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt_a++;
            if (busy) cnt_b++;
        end
        check_output("mid_rst_no_rsp", 256'(cnt_a), 256'(0));
        check_output("mid_rst_busy", 256'(cnt_b), 256'(0));

        // Per-port response counters.
        $display("[TB] stats");
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 7; k++) apply_stimulus(1'b0, FIPS_PT, FIPS_KEY, seen);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b1, APPX_PT, APPX_KEY, seen);
        wait_drain();
        check_output("stats_rsp0_seen", 256'(rsp0_seen), 256'(7));
        check_output("stats_rsp1_seen", 256'(rsp1_seen), 256'(3));
`ifdef AES_CTRL_STATS_EN
        exp0 = 7;
        exp1 = 3;
`else
        exp0 = 0;
        exp1 = 0;
`endif
        check_output("stats_cnt0", 256'(cnt0), 256'(exp0));
        check_output("stats_cnt1", 256'(cnt1), 256'(exp1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
